ram_stream_reader: RTL and testbench

Read-side streaming engine for the on-chip block RAM buffers of the systolic array. On `start` it reads `num_words` words from the buffer, beginning at `base_addr` and advancing by `stride`. It drives the RAM's read port and returns the words in order on a valid/ready stream toward the array feeder, asserting `m_last` on the final word. An internal credit-controlled FIFO absorbs the RAM read latency, so backpressure never drops or duplicates a word.

---
 rtl/ram_stream_reader.sv | 214 +++++++++++++++++++++
 tb/tb_ram_stream_reader.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: strided block-RAM read engine that returns words on a valid/ready
// stream, using a credit-controlled FIFO to absorb the RAM read latency.

module ram_stream_reader_chk #(
    parameter int CW         = 3,
    parameter int FIFO_DEPTH = 4
) (
    input logic          clk,
    input logic          reset,
    input logic          push_i,
    input logic [CW-1:0] count_i
);
    localparam logic [CW-1:0] FULL_C = CW'(FIFO_DEPTH);

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push_i && (count_i == FULL_C)));
endmodule

module ram_stream_reader #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 12,
    parameter int LEN_WIDTH    = 12,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic        [ADDR_WIDTH-1:0] base_addr,
    input  logic        [ADDR_WIDTH-1:0] stride,
    input  logic        [LEN_WIDTH-1:0]  num_words,
    output logic                         busy,
    output logic                         done,
    output logic                         ram_read_req,
    output logic        [ADDR_WIDTH-1:0] ram_read_addr,
    input  logic signed [DATA_WIDTH-1:0] ram_read_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic signed [DATA_WIDTH-1:0] m_data,
    output logic                         m_last
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]        DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
    localparam logic [PW-1:0]        PTR_ONE  = PW'(1);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]  stride_q, stride_d;
    logic [LEN_WIDTH-1:0]   num_q, num_d;
    logic [LEN_WIDTH-1:0]   issued_q, issued_d;
    logic [LEN_WIDTH-1:0]   accepted_q, accepted_d;
    logic                   done_q, done_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic signed [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

    logic                   req_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   valid_s;
    logic                   inflight_s;
    logic [LEN_WIDTH-1:0]   acc_next_s;

    assign valid_s    = (count_q != '0);
    assign pop_s      = valid_s && m_ready;
    assign acc_next_s = accepted_q + (pop_s ? LEN_ONE : LEN_ZERO);

    // A read may only issue when its word is guaranteed a FIFO slot on arrival.
    always_comb begin
        req_s = (state_q == S_ISSUE) && (issued_q < num_q) &&
                ((count_q + {{(CW-1){1'b0}}, inflight_s}) < DEPTH_C);
    end

    generate
        if (READ_LATENCY == 0) begin : g_comb_read
            assign push_s     = req_s;
            assign inflight_s = 1'b0;
        end else begin : g_reg_read
            logic inflight_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    inflight_q <= 1'b0;
                end else begin
                    inflight_q <= req_s;
                end
            end

            assign push_s     = inflight_q;
            assign inflight_s = inflight_q;
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        stride_d   = stride_q;
        num_d      = num_q;
        issued_d   = issued_q;
        accepted_d = acc_next_s;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d     = base_addr;
                    stride_d   = stride;
                    num_d      = num_words;
                    issued_d   = LEN_ZERO;
                    accepted_d = LEN_ZERO;
                    state_d    = (num_words == LEN_ZERO) ? S_DRAIN : S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (req_s) begin
                    issued_d = issued_q + LEN_ONE;
                    addr_d   = addr_q + stride_q;
                    if ((issued_q + LEN_ONE) == num_q) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_DRAIN: begin
                // done is registered, so leave IDLE-bound only after it has been shown.
                if (done_q) begin
                    state_d = S_IDLE;
                end else if (acc_next_s == num_q) begin
                    done_d = 1'b1;
                end else begin
                    done_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            stride_q   <= '0;
            num_q      <= '0;
            issued_q   <= '0;
            accepted_q <= '0;
            done_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            stride_q   <= stride_d;
            num_q      <= num_d;
            issued_q   <= issued_d;
            accepted_q <= accepted_d;
            done_q     <= done_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem[wr_ptr_q] <= ram_read_data;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign ram_read_req  = req_s;
    assign ram_read_addr = addr_q;
    assign m_valid       = valid_s;
    assign m_data        = valid_s ? fifo_mem[rd_ptr_q] : '0;
    assign m_last        = valid_s && (accepted_q == (num_q - LEN_ONE));

    ram_stream_reader_chk #(
        .CW         (CW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_chk (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_s),
        .count_i (count_q)
    );
endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: two instances (read latency 0 and 1) share stimulus;
// observed streams are compared with a queue-based model of the strided read.

module tb_ram_stream_reader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, m_ready;
    logic [11:0] base_addr, stride, num_words;
    logic [1:0]  busy_w, done_w, req_w, mv_w, ml_w;
    logic [1:0][11:0] addr_w;
    logic [1:0][7:0]  md_w;
    logic [7:0]  rdata0, rdata1;
    logic [7:0]  mem [4096];

    int total = 0, bad = 0, cyc = 0;
    bit mon_clr = 1'b0;

    logic [11:0] addr_q [2][$];
    int          req_cyc [2][$];
    logic [7:0]  beat_q [2][$];
    bit          last_q [2][$];
    int          beat_cyc [2][$];
    int          done_cyc [2][$];
    int          iss [2], acc [2], max_out [2], stab_err [2], mv_cnt [2];
    bit          prev_stall [2];
    logic [7:0]  prev_data [2];

    logic [7:0]  exp_d[$];
    logic [11:0] exp_a[$];

    ram_stream_reader #(.READ_LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .stride(stride),
        .num_words(num_words), .busy(busy_w[0]), .done(done_w[0]), .ram_read_req(req_w[0]),
        .ram_read_addr(addr_w[0]), .ram_read_data(rdata0), .m_valid(mv_w[0]),
        .m_ready(m_ready), .m_data(md_w[0]), .m_last(ml_w[0]));

    ram_stream_reader #(.READ_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .stride(stride),
        .num_words(num_words), .busy(busy_w[1]), .done(done_w[1]), .ram_read_req(req_w[1]),
        .ram_read_addr(addr_w[1]), .ram_read_data(rdata1), .m_valid(mv_w[1]),
        .m_ready(m_ready), .m_data(md_w[1]), .m_last(ml_w[1]));

    assign rdata0 = mem[addr_w[0]];
    always @(posedge clk) if (req_w[1]) rdata1 <= mem[addr_w[1]];

    always @(posedge clk) cyc <= cyc + 1;

    // Record what each instance does; the test tasks judge the recordings.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mon_clr) begin
                addr_q[d].delete(); req_cyc[d].delete(); beat_q[d].delete();
                last_q[d].delete(); beat_cyc[d].delete(); done_cyc[d].delete();
                iss[d] = 0; acc[d] = 0; max_out[d] = 0; stab_err[d] = 0; mv_cnt[d] = 0;
                prev_stall[d] = 1'b0;
            end else begin
                if (req_w[d]) begin
                    addr_q[d].push_back(addr_w[d]); req_cyc[d].push_back(cyc); iss[d]++;
                end
                if (mv_w[d]) mv_cnt[d]++;
                if (mv_w[d] && m_ready) begin
                    beat_q[d].push_back(md_w[d]); last_q[d].push_back(ml_w[d]);
                    beat_cyc[d].push_back(cyc); acc[d]++;
                end
                if (done_w[d]) done_cyc[d].push_back(cyc);
                if (prev_stall[d] && mv_w[d] && (md_w[d] !== prev_data[d])) stab_err[d]++;
                if (iss[d] - acc[d] > max_out[d]) max_out[d] = iss[d] - acc[d];
                prev_stall[d] = mv_w[d] && !m_ready;
                prev_data[d]  = md_w[d];
            end
        end
    end

    task automatic clear_mon();
        @(posedge clk); #1 mon_clr = 1'b1;
        @(posedge clk); #1 mon_clr = 1'b0;
    endtask

    task automatic build_model(input int b, input int st, input int n);
        exp_d.delete(); exp_a.delete();
        for (int i = 0; i < n; i++) begin
            int a;
            a = (b + i * st) % 4096;
            exp_a.push_back(12'(a));
            exp_d.push_back(mem[a]);
        end
    endtask

    task automatic do_start(input logic [11:0] b, input logic [11:0] st, input logic [11:0] n,
                            output int s);
        @(posedge clk); #1;
        base_addr = b; stride = st; num_words = n; start = 1'b1; s = cyc;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (!busy_w[0] && !busy_w[1]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; m_ready = 1'b0;
        base_addr = 12'd0; stride = 12'd0; num_words = 12'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++;
            if ({busy_w[d], done_w[d], req_w[d], addr_w[d], mv_w[d], md_w[d], ml_w[d]} !== 25'd0)
                begin bad++; $display("FAIL reset_outputs dut%0d got busy=%0b done=%0b req=%0b addr=%0h valid=%0b data=%0h last=%0b want all 0",
                    d, busy_w[d], done_w[d], req_w[d], addr_w[d], mv_w[d], md_w[d], ml_w[d]); end
        end
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_basic();
        int s; bit ok;
        m_ready = 1'b1;
        clear_mon();
        build_model(0, 1, 8);
        do_start(12'h000, 12'd1, 12'd8, s);
        wait_idle(80, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_timeout got busy still high want idle within 80 cycles"); end
        for (int d = 0; d < 2; d++) begin
            total++;
            if (beat_q[d].size() != 8) begin bad++; $display("FAIL basic_count dut%0d got %0d want 8", d, beat_q[d].size()); end
            for (int i = 0; i < beat_q[d].size() && i < 8; i++) begin
                total++;
                if (beat_q[d][i] !== 8'(i + 1) || last_q[d][i] !== (i == 7) || beat_cyc[d][i] != s + 2 + d + i) begin
                    bad++;
                    $display("FAIL basic_beat dut%0d i=%0d got data=%0d last=%0b cyc=%0d want data=%0d last=%0b cyc=%0d",
                             d, i, beat_q[d][i], last_q[d][i], beat_cyc[d][i], i + 1, (i == 7), s + 2 + d + i);
                end
            end
            total++;
            if (req_cyc[d].size() != 8 || req_cyc[d][0] != s + 1 || req_cyc[d][7] != s + 8) begin
                bad++; $display("FAIL basic_req dut%0d got n=%0d first=%0d want n=8 first=%0d consecutive",
                                d, req_cyc[d].size(), req_cyc[d][0], s + 1);
            end
            total++;
            if (done_cyc[d].size() != 1 || done_cyc[d][0] != beat_cyc[d][7] + 1) begin
                bad++; $display("FAIL basic_done dut%0d got n=%0d cyc=%0d want n=1 cyc=%0d",
                                d, done_cyc[d].size(), done_cyc[d][0], beat_cyc[d][7] + 1);
            end
        end
    endtask

    task automatic test_wrap();
        int s; bit ok;
        m_ready = 1'b1;
        clear_mon();
        build_model(12'hFFE, 3, 4);
        do_start(12'hFFE, 12'd3, 12'd4, s);
        wait_idle(60, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL wrap_timeout got busy still high want idle"); end
        for (int d = 0; d < 2; d++) begin
            total++;
            if (addr_q[d].size() != 4 || beat_q[d].size() != 4) begin
                bad++; $display("FAIL wrap_count dut%0d got reads=%0d beats=%0d want 4 and 4", d, addr_q[d].size(), beat_q[d].size());
            end
            for (int i = 0; i < addr_q[d].size() && i < 4; i++) begin
                total++;
                if (addr_q[d][i] !== exp_a[i]) begin
                    bad++; $display("FAIL wrap_addr dut%0d i=%0d got %0h want %0h", d, i, addr_q[d][i], exp_a[i]);
                end
            end
            for (int i = 0; i < beat_q[d].size() && i < 4; i++) begin
                total++;
                if (beat_q[d][i] !== exp_d[i]) begin
                    bad++; $display("FAIL wrap_data dut%0d i=%0d got %0h want %0h", d, i, beat_q[d][i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int s, b, st; bit ok;
        m_ready = 1'b0;
        b  = $urandom_range(0, 4095);
        st = $urandom_range(1, 9);
        clear_mon();
        build_model(b, st, 64);
        do_start(12'(b), 12'(st), 12'd64, s);
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1 m_ready = ($urandom_range(0, 9) < 3);
            @(negedge clk);
            if (!busy_w[0] && !busy_w[1]) begin ok = 1'b1; break; end
        end
        m_ready = 1'b1;
        total++;
        if (!ok) begin bad++; $display("FAIL bp_timeout got busy still high want idle within 3000 cycles"); end
        for (int d = 0; d < 2; d++) begin
            int errs;
            errs = 0;
            for (int i = 0; i < beat_q[d].size() && i < 64; i++)
                if (beat_q[d][i] !== exp_d[i] || last_q[d][i] !== (i == 63)) errs++;
            total++;
            if (beat_q[d].size() != 64 || errs != 0) begin
                bad++; $display("FAIL bp_stream dut%0d got beats=%0d wrong=%0d want beats=64 wrong=0", d, beat_q[d].size(), errs);
            end
            total++;
            if (stab_err[d] != 0) begin bad++; $display("FAIL bp_stable dut%0d got %0d changes while stalled want 0", d, stab_err[d]); end
            total++;
            if (max_out[d] > 4) begin bad++; $display("FAIL bp_credit dut%0d got max outstanding %0d want <= 4", d, max_out[d]); end
            total++;
            if (done_cyc[d].size() != 1) begin bad++; $display("FAIL bp_done dut%0d got %0d pulses want 1", d, done_cyc[d].size()); end
        end
    endtask

    task automatic test_stall_release();
        int s, r; bit ok;
        m_ready = 1'b0;
        clear_mon();
        build_model(12'h100, 1, 10);
        do_start(12'h100, 12'd1, 12'd10, s);
        repeat (19) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++;
            if (req_cyc[d].size() != 4) begin bad++; $display("FAIL stall_reads dut%0d got %0d want 4", d, req_cyc[d].size()); end
        end
        @(posedge clk); #1 m_ready = 1'b1; r = cyc;
        wait_idle(60, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL stall_timeout got busy still high want idle"); end
        for (int d = 0; d < 2; d++) begin
            int errs;
            errs = 0;
            for (int i = 0; i < beat_q[d].size() && i < 10; i++)
                if (beat_q[d][i] !== exp_d[i] || beat_cyc[d][i] != r + i) errs++;
            total++;
            if (beat_q[d].size() != 10 || errs != 0) begin
                bad++; $display("FAIL stall_drain dut%0d got beats=%0d wrong=%0d want beats=10 wrong=0 from cyc %0d", d, beat_q[d].size(), errs, r);
            end
        end
    endtask

    task automatic test_zero_and_ignored();
        int s; bit ok;
        m_ready = 1'b1;
        clear_mon();
        do_start(12'h055, 12'd1, 12'd0, s);
        wait_idle(20, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL zero_timeout got busy still high want idle"); end
        for (int d = 0; d < 2; d++) begin
            total++;
            if (req_cyc[d].size() != 0 || mv_cnt[d] != 0 || done_cyc[d].size() != 1 || done_cyc[d][0] != s + 2) begin
                bad++; $display("FAIL zero_len dut%0d got reads=%0d valid=%0d dones=%0d done_cyc=%0d want 0 0 1 %0d",
                                d, req_cyc[d].size(), mv_cnt[d], done_cyc[d].size(), done_cyc[d][0], s + 2);
            end
        end
        clear_mon();
        build_model(12'h200, 2, 8);
        do_start(12'h200, 12'd2, 12'd8, s);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 12'h300; stride = 12'd1; num_words = 12'd5;
        @(posedge clk); #1 start = 1'b0;
        wait_idle(80, ok);
        repeat (6) @(negedge clk);
        total++;
        if (!ok) begin bad++; $display("FAIL ignore_timeout got busy still high want idle"); end
        for (int d = 0; d < 2; d++) begin
            int errs;
            errs = 0;
            for (int i = 0; i < beat_q[d].size() && i < 8; i++)
                if (beat_q[d][i] !== exp_d[i]) errs++;
            total++;
            if (beat_q[d].size() != 8 || errs != 0 || req_cyc[d].size() != 8 || done_cyc[d].size() != 1) begin
                bad++; $display("FAIL ignore_start dut%0d got beats=%0d wrong=%0d reads=%0d dones=%0d want 8 0 8 1",
                                d, beat_q[d].size(), errs, req_cyc[d].size(), done_cyc[d].size());
            end
        end
    endtask

    task automatic test_reset_mid();
        int s; bit ok, seen;
        m_ready = 1'b1;
        clear_mon();
        build_model(12'h020, 1, 16);
        do_start(12'h020, 12'd1, 12'd16, s);
        seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (beat_q[1].size() >= 3) begin seen = 1'b1; break; end
        end
        total++;
        if (!seen) begin bad++; $display("FAIL rst_mid_wait got %0d beats want 3", beat_q[1].size()); end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++;
            if ({busy_w[d], done_w[d], req_w[d], addr_w[d], mv_w[d], md_w[d], ml_w[d]} !== 25'd0) begin
                bad++; $display("FAIL rst_mid_outputs dut%0d got busy=%0b done=%0b req=%0b addr=%0h valid=%0b data=%0h last=%0b want all 0",
                                d, busy_w[d], done_w[d], req_w[d], addr_w[d], mv_w[d], md_w[d], ml_w[d]);
            end
        end
        repeat (6) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++;
            if (done_cyc[d].size() != 0 || busy_w[d] !== 1'b0) begin
                bad++; $display("FAIL rst_mid_nodone dut%0d got dones=%0d busy=%0b want 0 0", d, done_cyc[d].size(), busy_w[d]);
            end
        end
        clear_mon();
        build_model(12'h040, 1, 2);
        do_start(12'h040, 12'd1, 12'd2, s);
        wait_idle(40, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rst_after_timeout got busy still high want idle"); end
        for (int d = 0; d < 2; d++) begin
            total++;
            if (beat_q[d].size() != 2 || beat_q[d][0] !== exp_d[0] || beat_q[d][1] !== exp_d[1] ||
                last_q[d][0] !== 1'b0 || last_q[d][1] !== 1'b1) begin
                bad++; $display("FAIL rst_after_stream dut%0d got beats=%0d d0=%0h d1=%0h want 2 %0h %0h last on second",
                                d, beat_q[d].size(), beat_q[d][0], beat_q[d][1], exp_d[0], exp_d[1]);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; m_ready = 1'b0;
        base_addr = 12'd0; stride = 12'd0; num_words = 12'd0;
        for (int i = 0; i < 4096; i++) mem[i] = (i < 8) ? 8'(i + 1) : 8'($urandom_range(0, 255));
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_stall_release();
        test_zero_and_ignored();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
